application_selector_lcd_dfa_64_to_32: RTL and testbench
========================================================

# application_selector_lcd_dfa_64_to_32

Avalon-ST data-format adapter that narrows the 64-bit LCD pixel stream to 32 bits. It sits directly downstream of the SGDMA-to-FIFO timing adapter and its FIFO, and feeds the 32-bit LCD pixel pipeline. Each 64-bit beat is split into one or two 32-bit beats. Packet framing (sop/eop) and byte-level `empty` are preserved, and the block raises a sticky framing-error flag.

## Interface
Parameters:
- `SYMBOL_W`, 8: bits per symbol; fixed, not overridable.
- `IN_SYMBOLS`, 8: symbols per input beat; fixed.
- `OUT_SYMBOLS`, 4: symbols per output beat; fixed.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_ready`  out  1  sink ready, ready latency 0.
- `in_valid`  in  1  sink valid.
- `in_data`  in  64  symbol 0 in bits [63:56], symbol 7 in bits [7:0] (first symbol in MSBs).
- `in_startofpacket`  in  1  first beat of packet.
- `in_endofpacket`  in  1  last beat of packet.
- `in_empty`  in  3  unused trailing symbols; meaningful only with eop.
- `out_ready`  in  1  source ready, ready latency 0.
- `out_valid`  out  1  source valid.
- `out_data`  out  32  symbol 0 in bits [31:24].
- `out_startofpacket`  out  1
- `out_endofpacket`  out  1
- `out_empty`  out  2
- `error`  out  1  sticky framing error; cleared only by `reset`.

## Operation
- A holding register stores one accepted input beat: `hd[63:0]`, `hs`, `he`, `hm[2:0]`.
- State machine has three states:
  - IDLE: holding register empty.
  - HI: presenting `hd[63:32]`.
  - LO: presenting `hd[31:0]`.
- `single` = `he && hm >= 4` (the beat fits in one 32-bit word).
- `last` = (state==LO) || (state==HI && single).
- `in_ready` = !reset && (state==IDLE || (out_ready && last)).
- On accept (`in_valid && in_ready`):
  - Load the holding register. If `in_endofpacket`=0, `hm` is loaded as 0.
  - Next state is HI.
- In HI, when `out_ready`:
  - If `single`: go to HI if a new beat is accepted the same cycle, else IDLE.
  - Otherwise go to LO.
- In LO, when `out_ready`: go to HI if a new beat is accepted the same cycle, else IDLE.
- Outputs come only from registered state. There is no combinational in→out path except `in_ready` from `out_ready`.
  - `out_valid` = state != IDLE.
  - In HI: `out_data` = `hd[63:32]`; `out_startofpacket` = `hs`; `out_endofpacket` = `single`; `out_empty` = `single ? hm-4 : 0` (2 LSBs).
  - In LO: `out_data` = `hd[31:0]`; `out_startofpacket` = 0; `out_endofpacket` = `he`; `out_empty` = `he ? hm[1:0] : 0`.
  - In IDLE: all data and side-band outputs are 0.
- Framing tracker: an `in_pkt` flag is set by an accepted beat with sop && !eop and cleared by an accepted beat with eop. `error` is set on any accepted beat where:
  - sop && `in_pkt`;
  - !sop && !`in_pkt`;
  - `in_empty` != 0 && !eop.
- A framing error does not alter data handling; the beat is forwarded as received.
- Source holds `out_valid` and all outputs stable while `out_ready`=0.

## Timing
- Reset values: state IDLE; `out_valid`=0; `out_data`=0; `out_startofpacket`=0; `out_endofpacket`=0; `out_empty`=0; `error`=0; `in_pkt`=0; holding register 0. `in_ready`=0 while `reset` is high, and 1 in the first cycle after release.
- Latency: input accepted at edge N is presented in cycle N+1.
- Throughput:
  - Two-word beats: one input beat per 2 cycles, 100% output utilisation.
  - Single-word eop beats: one per cycle.
- Back-to-back: a new beat is accepted in the same cycle the last half is consumed, so no bubble appears.
- Reset mid-packet: the holding register is discarded immediately, no partial output is completed, and the framing state is cleared.
- Backpressure: `out_ready` low for any number of cycles stalls in HI or LO with no loss or duplication.

## Test plan
- Single beat: sop+eop, `in_data`=0x0011223344556677, empty=0 → cycle 1 outputs 0x00112233 (sop=1, eop=0, empty=0); cycle 2 outputs 0x44556677 (sop=0, eop=1, empty=0); then `out_valid`=0.
- Short tail: sop+eop, data 0xAABBCCDD_xxxxxxxx, empty=5 → exactly one beat 0xAABBCCDD with sop=1, eop=1, empty=1; `in_ready`=1 on the next cycle.
- Streaming 3-beat packet with `out_ready` held 1 and `in_valid` continuous → 6 output beats on consecutive cycles with no bubble. Final beat with empty=2 gives last output eop=1, empty=2. `in_ready` toggles 0/1.
- Random backpressure (`out_ready` 50%) over 1000 random packets → output byte stream, sop/eop positions and trailing bytes match a reference model; `out_*` stable whenever valid && !ready; `error`=0.
- Framing errors: two sop beats without eop → `error`=1 from the cycle after the second accept and stays 1. Separately, empty=3 on a non-eop beat → `error`=1, and the forwarded words show empty=0.
- Reset asserted while in LO → `out_valid`=0 and `in_ready`=0 asynchronously; after release, the next packet is output from its sop with no residue.

Source files
------------

// File: rtl/application_selector_lcd_dfa_64_to_32.sv
// ---------------------------------------------------------------------------
// application_selector_lcd_dfa_64_to_32
//
// Avalon-ST width adapter that narrows the 64-bit LCD pixel stream to 32 bits.
// Each accepted 64-bit beat is parked in a holding register and replayed as
// one or two 32-bit beats (upper half first). A beat that ends a packet with
// four or more empty symbols fits in the upper half and is sent as a single
// word. Packet framing and the byte-level empty count are carried through.
// A sticky framing-error flag watches the incoming sop/eop/empty sequence.
//
// Ports
//   clk                sole clock, rising edge
//   reset              asynchronous, active-high
//   in_ready           sink ready (ready latency 0)
//   in_valid           sink valid
//   in_data[63:0]      symbol 0 in [63:56]
//   in_startofpacket   first beat of a packet
//   in_endofpacket     last beat of a packet
//   in_empty[2:0]      unused trailing symbols, meaningful only with eop
//   out_ready          source ready (ready latency 0)
//   out_valid          source valid
//   out_data[31:0]     symbol 0 in [31:24]
//   out_startofpacket  first word of a packet
//   out_endofpacket    last word of a packet
//   out_empty[1:0]     unused trailing symbols of the last word
//   error              sticky framing error, cleared only by reset
// ---------------------------------------------------------------------------
module application_selector_lcd_dfa_64_to_32 #(
    localparam int SYMBOL_W    = 8,
    localparam int IN_SYMBOLS  = 8,
    localparam int OUT_SYMBOLS = 4,
    localparam int IN_W        = SYMBOL_W * IN_SYMBOLS,
    localparam int OUT_W       = SYMBOL_W * OUT_SYMBOLS,
    localparam int IN_EMPTY_W  = $clog2(IN_SYMBOLS),
    localparam int OUT_EMPTY_W = $clog2(OUT_SYMBOLS)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   in_ready,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_startofpacket,
    input  logic                   in_endofpacket,
    input  logic [IN_EMPTY_W-1:0]  in_empty,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_startofpacket,
    output logic                   out_endofpacket,
    output logic [OUT_EMPTY_W-1:0] out_empty,
    output logic                   error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_t;

    state_t                  state;
    logic [IN_W-1:0]         hd;
    logic                    hs;
    logic                    he;
    logic [IN_EMPTY_W-1:0]   hm;
    logic                    in_pkt;

    state_t                  state_nxt;
    logic [IN_W-1:0]         hd_nxt;
    logic                    hs_nxt;
    logic                    he_nxt;
    logic [IN_EMPTY_W-1:0]   hm_nxt;
    logic                    in_pkt_nxt;
    logic                    error_nxt;

    logic                    single;
    logic                    single_nxt;
    logic                    last;
    logic                    accept;
    logic                    frame_bad;

    logic                    out_valid_nxt;
    logic [OUT_W-1:0]        out_data_nxt;
    logic                    out_sop_nxt;
    logic                    out_eop_nxt;
    logic [OUT_EMPTY_W-1:0]  out_empty_nxt;

    always_comb begin
        // A closing beat with at least OUT_SYMBOLS empty symbols has no
        // payload in its lower half.
        single = he && (hm >= IN_EMPTY_W'(OUT_SYMBOLS));
        last   = (state == ST_LO) || ((state == ST_HI) && single);

        in_ready = !reset && ((state == ST_IDLE) || (out_ready && last));
        accept   = in_valid && in_ready;

        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_HI;
            end
            ST_HI: begin
                if (out_ready) begin
                    if (single) state_nxt = accept ? ST_HI : ST_IDLE;
                    else        state_nxt = ST_LO;
                end
            end
            ST_LO: begin
                if (out_ready) state_nxt = accept ? ST_HI : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        hd_nxt = hd;
        hs_nxt = hs;
        he_nxt = he;
        hm_nxt = hm;
        if (accept) begin
            hd_nxt = in_data;
            hs_nxt = in_startofpacket;
            he_nxt = in_endofpacket;
            // empty is only defined on the closing beat; mid-packet values
            // are dropped so they never reach the output.
            hm_nxt = in_endofpacket ? in_empty : '0;
        end

        frame_bad  = (in_startofpacket && in_pkt)
                  || (!in_startofpacket && !in_pkt)
                  || ((in_empty != '0) && !in_endofpacket);
        in_pkt_nxt = in_pkt;
        error_nxt  = error;
        if (accept) begin
            if (in_endofpacket)        in_pkt_nxt = 1'b0;
            else if (in_startofpacket) in_pkt_nxt = 1'b1;
            if (frame_bad)             error_nxt  = 1'b1;
        end

        // Outputs are decoded from the next state/holding contents so the
        // port values themselves come straight out of flops.
        single_nxt    = he_nxt && (hm_nxt >= IN_EMPTY_W'(OUT_SYMBOLS));
        out_valid_nxt = 1'b0;
        out_data_nxt  = '0;
        out_sop_nxt   = 1'b0;
        out_eop_nxt   = 1'b0;
        out_empty_nxt = '0;
        case (state_nxt)
            ST_HI: begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = hd_nxt[IN_W-1 -: OUT_W];
                out_sop_nxt   = hs_nxt;
                out_eop_nxt   = single_nxt;
                // hm - OUT_SYMBOLS keeps only the low bits when hm >= OUT_SYMBOLS
                out_empty_nxt = single_nxt ? hm_nxt[OUT_EMPTY_W-1:0] : '0;
            end
            ST_LO: begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = hd_nxt[OUT_W-1:0];
                out_sop_nxt   = 1'b0;
                out_eop_nxt   = he_nxt;
                out_empty_nxt = he_nxt ? hm_nxt[OUT_EMPTY_W-1:0] : '0;
            end
            default: begin
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            hd                <= '0;
            hs                <= 1'b0;
            he                <= 1'b0;
            hm                <= '0;
            in_pkt            <= 1'b0;
            error             <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= '0;
        end else begin
            state             <= state_nxt;
            hd                <= hd_nxt;
            hs                <= hs_nxt;
            he                <= he_nxt;
            hm                <= hm_nxt;
            in_pkt            <= in_pkt_nxt;
            error             <= error_nxt;
            out_valid         <= out_valid_nxt;
            out_data          <= out_data_nxt;
            out_startofpacket <= out_sop_nxt;
            out_endofpacket   <= out_eop_nxt;
            out_empty         <= out_empty_nxt;
        end
    end

endmodule

// File: tb/tb_application_selector_lcd_dfa_64_to_32.sv
// Testbench for application_selector_lcd_dfa_64_to_32: scoreboard of expected
// 32-bit words filled at input acceptance, drained by an output monitor.
module tb_application_selector_lcd_dfa_64_to_32;

    logic        clk;
    logic        reset;
    logic        in_ready;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic [2:0]  in_empty;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [1:0]  out_empty;
    logic        error;

    int total;
    int bad;
    int mode;   // 0: out_ready=1, 1: random, 2: out_ready=0

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  m;
    } word_t;

    word_t expq[$];

    application_selector_lcd_dfa_64_to_32 dut (
        .clk               (clk),
        .reset             (reset),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_startofpacket  (in_sop),
        .in_endofpacket    (in_eop),
        .in_empty          (in_empty),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_empty         (out_empty),
        .error             (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the beat carries 8-empty valid bytes (8 if not closing);
    // they are sent as ceil(bytes/4) words, the last word padded.
    function automatic void push_exp(input logic [63:0] d, input logic s,
                                     input logic e, input logic [2:0] m);
        int    nb;
        int    nw;
        word_t w;
        nb = e ? 8 - int'(m) : 8;
        nw = (nb + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            w.d = d[63 - 32*i -: 32];
            w.s = s && (i == 0);
            w.e = e && (i == nw - 1);
            w.m = w.e ? 2'(4*nw - nb) : 2'd0;
            expq.push_back(w);
        end
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom % 2);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops scoreboard on each handshake, checks stability under stall
    word_t mon_cur;
    word_t mon_exp;
    word_t prev_w;
    logic  prev_v;
    logic  prev_r;

    initial begin
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_w = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                mon_cur = {out_data, out_sop, out_eop, out_empty};
                if (prev_v && !prev_r) begin
                    chk("stall_valid", 64'(out_valid), 64'(1'b1));
                    chk("stall_beat", 64'(mon_cur), 64'(prev_w));
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got %h expected no beat", mon_cur);
                    end else begin
                        mon_exp = expq.pop_front();
                        chk("beat", 64'(mon_cur), 64'(mon_exp));
                    end
                end
                prev_v = out_valid;
                prev_r = out_ready;
                prev_w = mon_cur;
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
        logic acc;
        int   cnt;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_empty = m;
        in_valid = 1'b1;
        cnt = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                push_exp(d, s, e, m);
                break;
            end
            cnt++;
            if (cnt > 500) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", cnt);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (expq.size() != 0 || out_valid) begin
            bad++;
            $display("FAIL %s_drain: %0d words pending, expected 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expq.delete();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        mode     = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = '0;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_out_data", 64'(out_data), 64'(32'h0));
        chk("rst_sideband", 64'({out_sop, out_eop, out_empty}), 64'(4'h0));
        chk("rst_error", 64'(error), 64'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'(1'b1));

        // single two-word beat
        @(posedge clk);
        #1;
        send(64'h0011223344556677, 1'b1, 1'b1, 3'd0);
        wait_drain("single");
        @(negedge clk);
        chk("single_idle", 64'(out_valid), 64'(1'b0));

        // short tail: one word with empty=1
        @(posedge clk);
        #1;
        send(64'hAABBCCDD12345678, 1'b1, 1'b1, 3'd5);
        @(negedge clk);
        chk("tail_in_ready", 64'(in_ready), 64'(1'b1));
        chk("tail_eop", 64'({out_valid, out_eop, out_empty}), 64'(4'b1101));
        wait_drain("tail");

        // streaming 3-beat packet, no bubbles, in_ready alternates
        @(posedge clk);
        #1;
        fork
            begin
                send(64'h0102030405060708, 1'b1, 1'b0, 3'd0);
                send(64'h1112131415161718, 1'b0, 1'b0, 3'd0);
                send(64'h2122232425262728, 1'b0, 1'b1, 3'd2);
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 6; i++) begin
                    chk("stream_valid", 64'(out_valid), 64'(1'b1));
                    chk("stream_in_ready", 64'(in_ready), 64'(i % 2));
                    @(negedge clk);
                end
            end
        join
        wait_drain("stream");

        // framing error: two sop beats without eop
        @(posedge clk);
        #1;
        send(64'hA0A1A2A3A4A5A6A7, 1'b1, 1'b0, 3'd0);
        chk("err1_before", 64'(error), 64'(1'b0));
        send(64'hB0B1B2B3B4B5B6B7, 1'b1, 1'b0, 3'd0);
        chk("err1_set", 64'(error), 64'(1'b1));
        wait_drain("err1");
        repeat (3) @(negedge clk);
        chk("err1_sticky", 64'(error), 64'(1'b1));
        do_reset();
        chk("err_cleared", 64'(error), 64'(1'b0));

        // framing error: non-zero empty on a non-eop beat
        @(posedge clk);
        #1;
        send(64'hC0C1C2C3C4C5C6C7, 1'b1, 1'b0, 3'd0);
        chk("err2_before", 64'(error), 64'(1'b0));
        send(64'hD0D1D2D3D4D5D6D7, 1'b0, 1'b0, 3'd3);
        chk("err2_set", 64'(error), 64'(1'b1));
        send(64'hE0E1E2E3E4E5E6E7, 1'b0, 1'b1, 3'd0);
        wait_drain("err2");
        chk("err2_sticky", 64'(error), 64'(1'b1));
        do_reset();

        // reset while presenting the lower half
        @(posedge clk);
        #1;
        send(64'hDEADBEEFCAFEF00D, 1'b1, 1'b0, 3'd0);
        @(posedge clk);
        #2;
        mode = 2;
        out_ready = 1'b0;
        @(negedge clk);
        chk("lo_stalled", 64'({out_valid, out_data}), 64'({1'b1, 32'hCAFEF00D}));
        #1;
        reset = 1'b1;
        #1;
        chk("rst_lo_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_lo_in_ready", 64'(in_ready), 64'(1'b0));
        expq.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mode = 0;
        #1;
        chk("rst_lo_release", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        send(64'h5566778899AABBCC, 1'b1, 1'b1, 3'd1);
        wait_drain("after_rst");
        chk("after_rst_error", 64'(error), 64'(1'b0));

        // random packets with random backpressure
        mode = 1;
        @(posedge clk);
        #1;
        for (int p = 0; p < 1000; p++) begin
            int len;
            len = 1 + int'($urandom % 4);
            for (int b = 0; b < len; b++) begin
                logic [63:0] d;
                logic        e;
                logic [2:0]  m;
                d = {$urandom, $urandom};
                e = (b == len - 1);
                m = e ? 3'($urandom % 8) : 3'd0;
                send(d, b == 0, e, m);
                if ($urandom % 4 == 0) begin
                    repeat (1 + $urandom % 3) @(posedge clk);
                    #1;
                end
            end
        end
        wait_drain("random");
        chk("random_error", 64'(error), 64'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
